regfile_write_scheduler: RTL and testbench
==========================================

// Module: regfile_write_scheduler
// PURPOSE
//  Shares the single write port of the 32 x 32-bit register file among NUM_REQ requesters.
//  Round-robin arbitration; drives per-register load enables (ld) and the common data bus (Din).
//  After every reset, sequences a zero-fill of all registers before it accepts any request.
//  Sits between the execution/writeback sources and the Register_32bit array.
// PARAMETERS
//  NUM_REQ   4    number of write requesters (2..8)
//  NUM_REGS  32   registers in the file; rf_ld width
//  DW        32   data width
//  AW        5    address width (localparam, $clog2(NUM_REGS))
// PORTS
//  clk       in   1            rising-edge clock
//  rst       in   1            synchronous, active-high reset
//  req       in   NUM_REQ      per-requester write request, held until granted
//  req_addr  in   NUM_REQ*AW   packed addresses, requester i at [i*AW +: AW]
//  req_data  in   NUM_REQ*DW   packed data, requester i at [i*DW +: DW]
//  gnt       out  NUM_REQ      one-hot accept; same-cycle req&gnt = transfer
//  rf_ld     out  NUM_REGS     registered one-hot load enables to the register file
//  rf_din    out  DW           registered write data to the register file
//  clr_busy  out  1            high while the zero-fill sequence runs
//  addr_err  out  1            registered 1-cycle pulse: accepted write with addr >= NUM_REGS
// BEHAVIOUR
//  Reset (rst=1 at edge): state<=CLEAR, clr_idx<=0, rr_ptr<=0, rf_ld<=0, rf_din<=0,
//   addr_err<=0, clr_busy<=1. gnt is 0 while rst=1. A reset mid-operation aborts any
//   fill or write: no rf_ld pulse in the cycle after the reset edge.
//  FSM: CLEAR -> ARB when clr_idx==NUM_REGS-1 is issued. ARB -> CLEAR only on rst.
//  CLEAR: each cycle rf_ld<=1<<clr_idx, rf_din<=0, clr_idx++. NUM_REGS cycles total.
//   gnt=0 throughout; clr_busy drops the cycle state becomes ARB.
//  ARB: gnt is combinational from req and rr_ptr. It grants the first asserted req at
//   index rr_ptr, rr_ptr+1, ... mod NUM_REQ. At most one gnt bit per cycle.
//   On grant k: rr_ptr<=(k+1)%NUM_REQ. Next edge: rf_ld<=1<<addr_k, rf_din<=data_k.
//   With no request: rr_ptr holds, and rf_ld<=0 on the next edge.
//  Latency: accept in cycle N -> rf_ld/rf_din valid in cycle N+1 for exactly one cycle.
//   Throughput is 1 write per cycle, and back-to-back grants are allowed.
//  Wrap-around: rr_ptr wraps from NUM_REQ-1 to 0. Fairness: a continuously asserted
//   req is granted within NUM_REQ cycles.
//  Simultaneous requests to the same address are serialised in grant order; the last grant wins.
//  Out-of-range addr (NUM_REGS not a power of 2): the request is granted, rf_ld stays 0,
//   and addr_err pulses.
//  rf_ld never has more than one bit set. rf_din holds its value when rf_ld==0.
// CONFIGURATION
//  RF_R0_PROTECT_EN defined: an accepted write to address 0 is granted (consumed), but
//   rf_ld[0] stays 0, so register 0 always reads zero. The CLEAR fill still loads reg 0.
//  Undefined: register 0 is an ordinary writable register.
// STRUCTURE
//  Package regfile_pkg: state enum {CLEAR, ARB}; default NUM_REGS/DW constants; AW function.
//  Sub-module rr_arbiter (NUM_REQ): req, ptr -> one-hot gnt, gnt_idx; purely combinational.
//  Top: FSM, clr_idx counter, rr_ptr register, address decode, output registers.
// TESTING
//  1 rst high 2 cycles, then low -> clr_busy high for 32 cycles; rf_ld walks 1<<0..1<<31;
//    rf_din=0; gnt=0 throughout.
//  2 After fill, req=4'b0001, addr=5, data=32'hA5 -> gnt=0001 same cycle;
//    next cycle rf_ld=1<<5, rf_din=32'hA5.
//  3 req=4'b1111 held 8 cycles from rr_ptr=0 -> gnt sequence 1,2,4,8,1,2,4,8;
//    rf_ld valid every cycle.
//  4 req0 and req2 both addr 7 (data 10, 20) -> two writes in grant order;
//    final rf_din for reg 7 = 20.
//  5 rst asserted mid-fill at clr_idx=12 -> no rf_ld pulse after the edge;
//    fill restarts at reg 0 and lasts 32 cycles.
//  6 RF_R0_PROTECT_EN: req1 addr=0 data=99 -> gnt=0010, rf_ld=0 next cycle.
//    Without the macro: rf_ld=1, rf_din=99.

Source files
------------

// File: rtl/regfile_pkg.sv
// Purpose : shared types and constants for the register-file write scheduler.
// Contents: FSM state enum, default geometry constants, address-width helper.
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_e;

  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned DW_DEF       = 32;

  // Index width for n items; never below one bit so every bus stays legal.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose : combinational round-robin arbiter; grants the first request found
//           at i_ptr, i_ptr+1, ... (mod NUM_REQ).
// Ports   : i_req     - request vector
//           i_ptr     - highest-priority index this cycle
//           o_gnt     - one-hot grant (zero when nothing requests)
//           o_gnt_idx - index of the granted requester
//           o_gnt_vld - a grant exists this cycle
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [addr_w(NUM_REQ)-1:0]  i_ptr,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [addr_w(NUM_REQ)-1:0]  o_gnt_idx,
  output logic                        o_gnt_vld
);

  localparam int unsigned PW = addr_w(NUM_REQ);

  int unsigned w_idx;

  // Scan from the pointer upward with wrap; the first hit wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_idx     = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      w_idx = (32'(i_ptr) + off) % NUM_REQ;
      if (!o_gnt_vld && i_req[PW'(w_idx)]) begin
        o_gnt_vld           = 1'b1;
        o_gnt[PW'(w_idx)]   = 1'b1;
        o_gnt_idx           = PW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Purpose : shares the single write port of the register file among NUM_REQ
//           requesters with round-robin arbitration; zero-fills every register
//           after reset before accepting requests.
// Config  : RF_R0_PROTECT_EN - when defined, accepted writes to register 0 are
//           consumed without loading, so register 0 always reads zero.
// Ports   : i_clk, i_rst       - clock, synchronous active-high reset
//           i_req              - per-requester write request
//           i_req_addr         - packed addresses, requester i at [i*AW +: AW]
//           i_req_data         - packed data, requester i at [i*DW +: DW]
//           o_gnt              - combinational one-hot accept
//           o_rf_ld, o_rf_din  - registered load enables / write data
//           o_clr_busy         - zero-fill in progress
//           o_addr_err         - pulse: accepted write with address >= NUM_REGS
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned DW       = DW_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*addr_w(NUM_REGS)-1:0] i_req_addr,
  input  logic [NUM_REQ*DW-1:0]         i_req_data,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic [NUM_REGS-1:0]           o_rf_ld,
  output logic [DW-1:0]                 o_rf_din,
  output logic                          o_clr_busy,
  output logic                          o_addr_err
);

  localparam int unsigned AW = addr_w(NUM_REGS);
  localparam int unsigned PW = addr_w(NUM_REQ);
  localparam logic [NUM_REGS-1:0] LD_ONE = NUM_REGS'(1);

  state_e              r_state;
  logic [AW-1:0]       r_clr_idx;
  logic [PW-1:0]       r_rr_ptr;
  logic [NUM_REGS-1:0] r_rf_ld;
  logic [DW-1:0]       r_rf_din;
  logic                r_clr_busy;
  logic                r_addr_err;

  logic [NUM_REQ-1:0]  w_arb_gnt;
  logic [PW-1:0]       w_gnt_idx;
  logic                w_arb_vld;
  logic                w_accept;
  logic [AW-1:0]       w_sel_addr;
  logic [DW-1:0]       w_sel_data;
  logic                w_addr_ok;
  logic                w_r0_block;
  logic [PW-1:0]       w_ptr_nxt;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req     (i_req),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_arb_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_vld (w_arb_vld)
  );

  // Grants only exist in ARB and are suppressed while reset is asserted.
  assign w_accept   = w_arb_vld && (r_state == ST_ARB) && !i_rst;
  assign o_gnt      = w_accept ? w_arb_gnt : '0;

  assign w_sel_addr = i_req_addr[32'(w_gnt_idx)*AW +: AW];
  assign w_sel_data = i_req_data[32'(w_gnt_idx)*DW +: DW];
  assign w_addr_ok  = 32'(w_sel_addr) < NUM_REGS;
  assign w_ptr_nxt  = (w_gnt_idx == PW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PW'(1);

`ifdef RF_R0_PROTECT_EN
  assign w_r0_block = (w_sel_addr == '0);
`else
  assign w_r0_block = 1'b0;
`endif

  // FSM, fill counter, round-robin pointer and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_CLEAR;
      r_clr_idx  <= '0;
      r_rr_ptr   <= '0;
      r_rf_ld    <= '0;
      r_rf_din   <= '0;
      r_clr_busy <= 1'b1;
      r_addr_err <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_rf_ld    <= LD_ONE << r_clr_idx;
          r_rf_din   <= '0;
          r_addr_err <= 1'b0;
          if (r_clr_idx == AW'(NUM_REGS - 1)) begin
            r_state    <= ST_ARB;
            r_clr_busy <= 1'b0;
            r_clr_idx  <= '0;
          end else begin
            r_clr_idx  <= r_clr_idx + AW'(1);
          end
        end
        ST_ARB: begin
          r_rf_ld    <= '0;
          r_addr_err <= 1'b0;
          if (w_accept) begin
            r_rr_ptr <= w_ptr_nxt;
            // Bad or protected addresses consume the request without loading.
            if (!w_addr_ok) begin
              r_addr_err <= 1'b1;
            end else if (!w_r0_block) begin
              r_rf_ld  <= LD_ONE << w_sel_addr;
              r_rf_din <= w_sel_data;
            end
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end

  assign o_rf_ld    = r_rf_ld;
  assign o_rf_din   = r_rf_din;
  assign o_clr_busy = r_clr_busy;
  assign o_addr_err = r_addr_err;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler (NUM_REQ=4, 32 x 32-bit file).
module tb_regfile_write_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [19:0] req_addr;
  logic [127:0] req_data;
  logic [3:0]  gnt;
  logic [31:0] rf_ld;
  logic [31:0] rf_din;
  logic        clr_busy;
  logic        addr_err;

  logic [4:0]  a [4];
  logic [31:0] d [4];
  logic [31:0] exp_din;

  int n_vec  = 0;
  int n_miss = 0;

  assign req_addr = {a[3], a[2], a[1], a[0]};
  assign req_data = {d[3], d[2], d[1], d[0]};

  regfile_write_scheduler #(.NUM_REQ(4), .NUM_REGS(32), .DW(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_req_addr (req_addr),
    .i_req_data (req_data),
    .o_gnt      (gnt),
    .o_rf_ld    (rf_ld),
    .o_rf_din   (rf_din),
    .o_clr_busy (clr_busy),
    .o_addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected write lands on the edge after the grant.
  task automatic grant_step(input string tag, input logic [3:0] exp_gnt,
                            input logic [4:0] addr, input logic [31:0] data);
    check({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
    tick();
    check({tag, "_ld"}, 64'(rf_ld), 64'(32'h1 << addr));
    check({tag, "_din"}, 64'(rf_din), 64'(data));
    check({tag, "_aerr"}, 64'(addr_err), 64'(1'b0));
    exp_din = data;
  endtask

  task automatic fill_check(input string tag);
    for (int k = 0; k < 32; k++) begin
      check({tag, "_gnt0"}, 64'(gnt), 64'(4'b0000));
      if (k == 31) req = 4'b0000;
      tick();
      check({tag, "_ld"}, 64'(rf_ld), 64'(32'h1 << k));
      check({tag, "_din"}, 64'(rf_din), 64'(0));
      check({tag, "_busy"}, 64'(clr_busy), 64'((k == 31) ? 1'b0 : 1'b1));
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin a[i] = 5'd0; d[i] = 32'd0; end
    exp_din = 32'd0;
    #1;
    check("rst_gnt", 64'(gnt), 64'(4'b0000));
    tick();
    tick();
    check("rst_ld", 64'(rf_ld), 64'(0));
    check("rst_din", 64'(rf_din), 64'(0));
    check("rst_busy", 64'(clr_busy), 64'(1'b1));
    check("rst_aerr", 64'(addr_err), 64'(1'b0));
    check("rst_gnt2", 64'(gnt), 64'(4'b0000));

    // Zero-fill with requests pending: no grants until it completes.
    rst = 1'b0;
    fill_check("fill");

    // Single write.
    a[0] = 5'd5; d[0] = 32'hA5; req = 4'b0001;
    #1;
    check("single_gnt", 64'(gnt), 64'(4'b0001));
    tick();
    req = 4'b0000;
    check("single_ld", 64'(rf_ld), 64'(32'h1 << 5));
    check("single_din", 64'(rf_din), 64'(32'hA5));

    // Requester 3 once so the pointer returns to 0.
    a[3] = 5'd1; d[3] = 32'h33; req = 4'b1000;
    #1;
    grant_step("align", 4'b1000, 5'd1, 32'h33);

    // All four requesting: strict rotation, one write every cycle.
    for (int i = 0; i < 4; i++) begin a[i] = 5'(8 + i); d[i] = 32'h100 + 32'(i); end
    req = 4'b1111;
    #1;
    for (int c = 0; c < 8; c++) begin
      grant_step("rot", 4'(1 << (c % 4)), 5'(8 + (c % 4)), 32'h100 + 32'(c % 4));
    end
    req = 4'b0000;
    tick();
    check("idle_ld", 64'(rf_ld), 64'(0));
    check("idle_din", 64'(rf_din), 64'(exp_din));

    // Same address from two requesters: serialised, last grant wins.
    a[0] = 5'd7; d[0] = 32'd10; a[2] = 5'd7; d[2] = 32'd20;
    req = 4'b0101;
    #1;
    grant_step("same0", 4'b0001, 5'd7, 32'd10);
    req = 4'b0100;
    #1;
    grant_step("same2", 4'b0100, 5'd7, 32'd20);
    req = 4'b0000;
    tick();
    check("same_idle_ld", 64'(rf_ld), 64'(0));
    check("same_final", 64'(rf_din), 64'(32'd20));

    // Pointer at 3: search wraps to requester 0, then 1.
    a[0] = 5'd3; d[0] = 32'h30; a[1] = 5'd4; d[1] = 32'h40;
    req = 4'b0011;
    #1;
    grant_step("wrap0", 4'b0001, 5'd3, 32'h30);
    req = 4'b0010;
    #1;
    grant_step("wrap1", 4'b0010, 5'd4, 32'h40);

    // Write to register 0 from requester 1 (pointer at 2).
    a[1] = 5'd0; d[1] = 32'd99;
    req = 4'b0010;
    #1;
    check("r0_gnt", 64'(gnt), 64'(4'b0010));
    tick();
    req = 4'b0000;
`ifdef RF_R0_PROTECT_EN
    check("r0_ld", 64'(rf_ld), 64'(0));
    check("r0_din", 64'(rf_din), 64'(exp_din));
`else
    check("r0_ld", 64'(rf_ld), 64'(1));
    check("r0_din", 64'(rf_din), 64'(32'd99));
`endif

    // Reset mid-fill at clr_idx=12: abort, then a full restart from reg 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 12; k++) tick();
    check("mid_ld11", 64'(rf_ld), 64'(32'h1 << 11));
    rst = 1'b1;
    #1;
    check("mid_rst_gnt", 64'(gnt), 64'(4'b0000));
    tick();
    check("mid_ld", 64'(rf_ld), 64'(0));
    check("mid_busy", 64'(clr_busy), 64'(1'b1));
    rst = 1'b0;
    fill_check("refill");
    tick();
    check("post_ld", 64'(rf_ld), 64'(0));
    check("post_busy", 64'(clr_busy), 64'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
